// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes, line levels.
// Used by both the transmit and receive shifters.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   localparam logic PAR_EVEN   = 1'b0;
   localparam logic PAR_ODD    = 1'b1;

   localparam logic LINE_IDLE  = 1'b1;
   localparam logic LINE_START = 1'b0;
   localparam logic LINE_STOP  = 1'b1;

   // Total bits on the line for one frame.
   function automatic int frame_bits(int data_bits, int parity_en, int stop_bits);
      return 1 + data_bits + parity_en + stop_bits;
   endfunction

endpackage

// File: rtl/uart_tx_piso_if.sv
// Host-side handshake and line outputs of the UART transmitter.
interface uart_tx_piso_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] tx_data;
   logic                 tx_valid;
   logic                 tx_ready;
   logic                 tx_serial;
   logic                 tx_busy;
   logic                 tx_done;

   modport master (output tx_data, tx_valid,
                   input  tx_ready, tx_serial, tx_busy, tx_done);

   modport slave  (input  tx_data, tx_valid,
                   output tx_ready, tx_serial, tx_busy, tx_done);
endinterface

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// terminal count. Clearing wins over counting so a new frame starts aligned.
module uart_baud_counter #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tick
);
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

   logic [CW-1:0] cnt;

   assign tick = en && (cnt == CW'(CLKS_PER_BIT - 1));

   // Count within a bit period, wrapping at the terminal count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clr || tick)
         cnt <= '0;
      else if (en)
         cnt <= cnt + CW'(1);
   end
endmodule

// File: rtl/uart_tx_piso.sv
// UART transmitter: takes a word on a valid/ready handshake and sends
// start, data, optional parity and stop bits, each CLKS_PER_BIT clocks long.
// All outputs come straight from flops.
module uart_tx_piso
   import uart_pkg::*;
#(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int MSB_FIRST    = 1,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic           clk,
   input  logic           rst,
   uart_tx_piso_if.slave  bus
);
   localparam int   BCW      = $clog2(DATA_BITS + 1);
   localparam logic PAR_MODE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

   uart_state_e          state;
   logic [DATA_BITS-1:0] shreg;
   logic [BCW-1:0]       bit_cnt;
   logic                 par_bit;
   logic                 ser_q, rdy_q, busy_q, done_q;
   logic                 tick, accept;
   logic                 out_bit;
   logic [DATA_BITS-1:0] shifted;

   assign accept = bus.tx_valid && rdy_q;

   // Next data bit on the line and the register after it has been consumed.
   assign out_bit = (MSB_FIRST != 0) ? shreg[DATA_BITS-1] : shreg[0];
   assign shifted = (MSB_FIRST != 0) ? {shreg[DATA_BITS-2:0], 1'b0}
                                     : {1'b0, shreg[DATA_BITS-1:1]};

   uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk  (clk),
      .rst  (rst),
      .clr  (accept),
      .en   (state != ST_IDLE),
      .tick (tick)
   );

   assign bus.tx_serial = ser_q;
   assign bus.tx_ready  = rdy_q;
   assign bus.tx_busy   = busy_q;
   assign bus.tx_done   = done_q;

   // Frame sequencer: advances one bit per baud tick and drives the line.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         shreg   <= '0;
         bit_cnt <= '0;
         par_bit <= 1'b0;
         ser_q   <= LINE_IDLE;
         rdy_q   <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: if (accept) begin
               shreg   <= bus.tx_data;
               par_bit <= (^bus.tx_data) ^ PAR_MODE;
               bit_cnt <= '0;
               state   <= ST_START;
               ser_q   <= LINE_START;
               rdy_q   <= 1'b0;
               busy_q  <= 1'b1;
            end
            ST_START: if (tick) begin
               state   <= ST_DATA;
               bit_cnt <= '0;
               ser_q   <= out_bit;
               shreg   <= shifted;
            end
            ST_DATA: if (tick) begin
               if (bit_cnt == BCW'(DATA_BITS - 1)) begin
                  bit_cnt <= '0;
                  if (PARITY_EN != 0) begin
                     state <= ST_PARITY;
                     ser_q <= par_bit;
                  end else begin
                     state <= ST_STOP;
                     ser_q <= LINE_STOP;
                  end
               end else begin
                  bit_cnt <= bit_cnt + BCW'(1);
                  ser_q   <= out_bit;
                  shreg   <= shifted;
               end
            end
            ST_PARITY: if (tick) begin
               state   <= ST_STOP;
               bit_cnt <= '0;
               ser_q   <= LINE_STOP;
            end
            ST_STOP: if (tick) begin
               if (bit_cnt == BCW'(STOP_BITS - 1)) begin
                  state   <= ST_IDLE;
                  bit_cnt <= '0;
                  ser_q   <= LINE_IDLE;
                  rdy_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  bit_cnt <= bit_cnt + BCW'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_piso.sv
// Directed and randomized checks of uart_tx_piso across four configurations,
// compared against a frame model built from the framing rules.
module tb_uart_tx_piso;
   localparam int C  = 4;
   localparam int DB = 8;
   localparam int ND = 4;
   localparam int CFG_MSB [ND] = '{1, 1, 1, 0};
   localparam int CFG_PE  [ND] = '{0, 1, 1, 0};
   localparam int CFG_PO  [ND] = '{0, 0, 1, 0};
   localparam int CFG_SB  [ND] = '{1, 1, 1, 2};

   localparam logic [3:0] IDLE_O = 4'b1010;  // {serial, busy, ready, done}
   localparam logic [3:0] DONE_O = 4'b1011;

   logic         clk, rst;
   logic [DB-1:0] d [ND];
   logic         v   [ND];
   logic         ser [ND];
   logic         bsy [ND];
   logic         rdy [ND];
   logic         dn  [ND];
   int           errors = 0;
   int           checks = 0;

   uart_tx_piso_if #(.DATA_BITS(DB)) b0 ();
   uart_tx_piso_if #(.DATA_BITS(DB)) b1 ();
   uart_tx_piso_if #(.DATA_BITS(DB)) b2 ();
   uart_tx_piso_if #(.DATA_BITS(DB)) b3 ();

   assign b0.tx_data = d[0]; assign b0.tx_valid = v[0];
   assign b1.tx_data = d[1]; assign b1.tx_valid = v[1];
   assign b2.tx_data = d[2]; assign b2.tx_valid = v[2];
   assign b3.tx_data = d[3]; assign b3.tx_valid = v[3];
   assign ser[0] = b0.tx_serial; assign bsy[0] = b0.tx_busy; assign rdy[0] = b0.tx_ready; assign dn[0] = b0.tx_done;
   assign ser[1] = b1.tx_serial; assign bsy[1] = b1.tx_busy; assign rdy[1] = b1.tx_ready; assign dn[1] = b1.tx_done;
   assign ser[2] = b2.tx_serial; assign bsy[2] = b2.tx_busy; assign rdy[2] = b2.tx_ready; assign dn[2] = b2.tx_done;
   assign ser[3] = b3.tx_serial; assign bsy[3] = b3.tx_busy; assign rdy[3] = b3.tx_ready; assign dn[3] = b3.tx_done;

   uart_tx_piso #(.DATA_BITS(DB), .CLKS_PER_BIT(C), .MSB_FIRST(CFG_MSB[0]), .PARITY_EN(CFG_PE[0]),
                  .PARITY_ODD(CFG_PO[0]), .STOP_BITS(CFG_SB[0])) dut0 (.clk(clk), .rst(rst), .bus(b0));
   uart_tx_piso #(.DATA_BITS(DB), .CLKS_PER_BIT(C), .MSB_FIRST(CFG_MSB[1]), .PARITY_EN(CFG_PE[1]),
                  .PARITY_ODD(CFG_PO[1]), .STOP_BITS(CFG_SB[1])) dut1 (.clk(clk), .rst(rst), .bus(b1));
   uart_tx_piso #(.DATA_BITS(DB), .CLKS_PER_BIT(C), .MSB_FIRST(CFG_MSB[2]), .PARITY_EN(CFG_PE[2]),
                  .PARITY_ODD(CFG_PO[2]), .STOP_BITS(CFG_SB[2])) dut2 (.clk(clk), .rst(rst), .bus(b2));
   uart_tx_piso #(.DATA_BITS(DB), .CLKS_PER_BIT(C), .MSB_FIRST(CFG_MSB[3]), .PARITY_EN(CFG_PE[3]),
                  .PARITY_ODD(CFG_PO[3]), .STOP_BITS(CFG_SB[3])) dut3 (.clk(clk), .rst(rst), .bus(b3));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hard stop in case the sequence ever stalls.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(string tag, logic [3:0] got, logic [3:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got {ser,busy,rdy,done}=%b expected %b", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] obs(int w);
      return {ser[w], bsy[w], rdy[w], dn[w]};
   endfunction

   function automatic int nbits(int w);
      return 1 + DB + CFG_PE[w] + CFG_SB[w];
   endfunction

   // Reference frame: bit k of the line sequence for word 'data' on DUT w.
   function automatic logic fbit(int w, logic [DB-1:0] data, int k);
      if (k == 0) return 1'b0;
      if (k <= DB) return (CFG_MSB[w] != 0) ? data[DB-k] : data[k-1];
      if (CFG_PE[w] != 0 && k == DB + 1) return (^data) ^ (CFG_PO[w] != 0);
      return 1'b1;
   endfunction

   // Offer a word (called at a negedge with ready high) and check every cycle
   // of its frame, then the done cycle. stop_at>0 ends early; poke_t pulses a
   // stray request with 0xFF mid-frame.
   task automatic send(int w, logic [DB-1:0] data, bit keep, int stop_at, int poke_t, string tag);
      d[w] = data;
      v[w] = 1'b1;
      @(posedge clk);
      #1;
      if (!keep) v[w] = 1'b0;
      d[w] = DB'($urandom);
      for (int t = 1; t <= nbits(w) * C; t++) begin
         @(negedge clk);
         chk($sformatf("%s t=%0d", tag, t), obs(w), {fbit(w, data, (t - 1) / C), 3'b100});
         if (t == poke_t) begin v[w] = 1'b1; d[w] = 8'hFF; end
         if (t == poke_t + 1) v[w] = 1'b0;
         if (t == stop_at) return;
      end
      @(negedge clk);
      chk($sformatf("%s done", tag), obs(w), DONE_O);
   endtask

   task automatic idle_chk(int w, int n, string tag);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk($sformatf("%s i=%0d", tag, i), obs(w), IDLE_O);
      end
   endtask

   initial begin
      rst = 1'b0;
      for (int w = 0; w < ND; w++) begin d[w] = '0; v[w] = 1'b0; end

      // Asynchronous reset before any clock edge.
      #1 rst = 1'b1;
      #1;
      for (int w = 0; w < ND; w++) chk($sformatf("reset_async w=%0d", w), obs(w), IDLE_O);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      idle_chk(0, 2, "idle0");

      // Single byte, MSB first, no parity.
      send(0, 8'hA5, 1'b0, 0, -1, "a5");
      idle_chk(0, 2, "a5_idle");

      // Back-to-back with tx_valid held high.
      send(0, 8'h00, 1'b1, 0, -1, "b2b0");
      send(0, 8'hFF, 1'b0, 0, -1, "b2b1");
      idle_chk(0, 2, "b2b_idle");

      // Parity even/odd on 0x07.
      send(1, 8'h07, 1'b0, 0, -1, "par_even");
      send(2, 8'h07, 1'b0, 0, -1, "par_odd");

      // Reset in the middle of data bit 3.
      send(0, 8'h5A, 1'b0, 18, -1, "pre_rst");
      #1 rst = 1'b1;
      #1 chk("rst_mid_async", obs(0), IDLE_O);
      idle_chk(0, 2, "rst_held");
      rst = 1'b0;
      idle_chk(0, 3, "post_rst");
      send(0, 8'h3C, 1'b0, 0, -1, "3c");

      // Stray request during a frame is ignored.
      send(0, 8'h81, 1'b0, 0, 12, "ign");
      idle_chk(0, 4, "ign_after");

      // Randomized words across all configurations.
      for (int i = 0; i < 40; i++) begin
         int w;
         w = int'($urandom_range(0, ND - 1));
         if ($urandom_range(0, 1) == 1) idle_chk(w, int'($urandom_range(1, 3)), $sformatf("rgap%0d", i));
         if ($urandom_range(0, 2) == 0) begin
            send(w, DB'($urandom), 1'b1, 0, -1, $sformatf("rb2b%0d_w%0d", i, w));
            send(w, DB'($urandom), 1'b0, 0, -1, $sformatf("rb2c%0d_w%0d", i, w));
         end else begin
            send(w, DB'($urandom), 1'b0, 0, -1, $sformatf("rnd%0d_w%0d", i, w));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
